// File: rtl/spi_dc_arbiter.sv
// Two-requester arbiter in front of a daisy-chained SPI master: grants one byte, runs one chain transaction, returns the echoed byte.
// Optional build macro SPI_DC_PRIO_EN: requester 0 gets fixed priority instead of round-robin.
module spi_dc_arbiter #(
  parameter int CAP_EDGE  = 27,
  parameter int END_EDGE  = 28,
  parameter int GAP_EDGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       busy,
  input  logic       link_sclk,
  output logic       link_newd,
  output logic [7:0] link_din,
  input  logic [7:0] link_dout,
  output logic [2:0] dbg_state
);

  // Handshake: a byte moves on a clk edge where reqN_valid && reqN_ready; ready is only
  // ever a single-cycle pulse in IDLE and never depends on a previously dropped valid.
  typedef enum logic [2:0] {DRAIN, IDLE, ALIGN, START, RUN, CAPTURE, DONE, GAP} state_t;

  localparam logic [4:0] CAP_CNT   = 5'(CAP_EDGE);
  localparam logic [4:0] END_CNT   = 5'(END_EDGE);
  localparam logic [4:0] GAP_CNT   = 5'(GAP_EDGES);
  localparam logic [4:0] DRAIN_CNT = 5'(END_EDGE + GAP_EDGES);

  state_t     state, state_next;
  logic [4:0] edge_cnt, edge_next, edge_inc;
  logic       wait_cnt, wait_next;
  logic       rr_last, owner;
  logic       any_valid, grant_id, grant, fire, cap;
  logic       sclk_q1, sclk_q2, sclk_q3;
  logic       rise, fall;

  // The link keeps running through reset, so the synchronizer is never cleared.
  always_ff @(posedge clk) begin
    sclk_q1 <= link_sclk;
    sclk_q2 <= sclk_q1;
    sclk_q3 <= sclk_q2;
  end

  assign rise      = sclk_q2 & ~sclk_q3;
  assign fall      = ~sclk_q2 & sclk_q3;
  assign edge_inc  = (edge_cnt == 5'd31) ? edge_cnt : edge_cnt + 5'd1;
  assign any_valid = req0_valid | req1_valid;

`ifdef SPI_DC_PRIO_EN
  assign grant_id = ~req0_valid;
`else
  assign grant_id = (req0_valid & req1_valid) ? ~rr_last : ~req0_valid;
`endif

  assign grant      = (state == IDLE) & any_valid & ~rst;
  assign req0_ready = grant & ~grant_id;
  assign req1_ready = grant & grant_id;
  assign busy       = rst | (state != IDLE);
  assign link_newd  = (state == START);
  assign dbg_state  = state;

  always_comb begin
    state_next = state;
    edge_next  = edge_cnt;
    wait_next  = wait_cnt;
    fire       = 1'b0;
    cap        = 1'b0;
    case (state)
      DRAIN: if (rise) begin
        edge_next = edge_inc;
        if (edge_inc == DRAIN_CNT) begin
          edge_next  = 5'd0;
          state_next = IDLE;
        end
      end
      IDLE:  if (any_valid) state_next = ALIGN;
      ALIGN: if (fall) state_next = START;
      START: if (rise) begin
        edge_next  = 5'd0;
        state_next = RUN;
      end
      RUN: if (rise) begin
        edge_next = edge_inc;
        if (edge_inc == CAP_CNT) begin
          wait_next  = 1'b0;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (rise) edge_next = edge_inc;
        if (wait_cnt) begin
          cap        = 1'b1;
          state_next = DONE;
        end else begin
          wait_next = 1'b1;
        end
      end
      DONE: if (rise) begin
        edge_next = edge_inc;
        if (edge_inc == END_CNT) begin
          fire       = 1'b1;
          edge_next  = 5'd0;
          state_next = GAP;
        end
      end
      GAP: if (rise) begin
        edge_next = edge_inc;
        if (edge_inc == GAP_CNT) begin
          edge_next  = 5'd0;
          state_next = IDLE;
        end
      end
      default: state_next = DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DRAIN;
      edge_cnt  <= 5'd0;
      wait_cnt  <= 1'b0;
      rr_last   <= 1'b1;
      owner     <= 1'b0;
      link_din  <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 8'd0;
    end else begin
      state     <= state_next;
      edge_cnt  <= edge_next;
      wait_cnt  <= wait_next;
      rsp_valid <= fire;
      if (fire) rsp_id <= owner;
      if (cap) rsp_data <= link_dout;
      if (grant) begin
        link_din <= grant_id ? req1_data : req0_data;
        owner    <= grant_id;
        rr_last  <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_spi_dc_arbiter.sv
// Bench for spi_dc_arbiter: behavioural chain master with a two-slave echo loop, transaction scoreboard,
// directed scenarios followed by randomized traffic.
module tb_spi_dc_arbiter;
  localparam int CAP_EDGE  = 27;
  localparam int END_EDGE  = 28;
  localparam int GAP_EDGES = 2;
  localparam int BUDGET    = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy, link_newd;
  logic [7:0] rsp_data, link_din;
  logic       link_sclk = 1'b0;
  logic [7:0] link_dout = 8'd0;
  logic [2:0] dbg_state;

  spi_dc_arbiter #(.CAP_EDGE(CAP_EDGE), .END_EDGE(END_EDGE), .GAP_EDGES(GAP_EDGES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
    .link_sclk(link_sclk), .link_newd(link_newd), .link_din(link_din), .link_dout(link_dout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard state: {id, byte} per accepted request
  logic [8:0] exp_q[$];
  int         grant_log[$];
  logic [7:0] rsp_log[$];
  int         hs_cnt = 0, rsp_cnt = 0;
  int         last_grant = 1;
  logic [7:0] gnt_byte = 8'd0;
  bit         in_txn = 0, din_bad = 0, drain_mode = 1, ready_prev = 0, prev_busy = 1;
  int         newd_w = 0;

  // chain master model state
  int         div_cnt = 0, m_cnt = 0, m_since = 1000;
  bit         m_active = 0;
  logic [7:0] slave0 = 8'd0, slave1 = 8'd0;
  int         rises_since_rst = 0, rises_since_rsp = 0;

  always @(negedge clk) begin
    // Chain master: sclk = clk/8; a newd seen on a rise starts a transfer, the byte
    // passes through both slaves and comes back only for the sclk period after rise CAP_EDGE.
    div_cnt++;
    if (div_cnt == 4) begin
      div_cnt   = 0;
      link_sclk = ~link_sclk;
      if (link_sclk) begin
        rises_since_rst++;
        rises_since_rsp++;
        m_since++;
        if (link_newd) check("newd_overlap", 32'(m_active), 32'd0);
        if (!m_active && link_newd) begin
          m_active = 1;
          m_cnt    = 0;
          m_since  = 0;
          slave0   = link_din;
          slave1   = slave0;
        end else if (m_active) begin
          m_cnt++;
          if (m_cnt == END_EDGE) m_active = 0;
        end
        link_dout = (m_active && m_cnt == CAP_EDGE) ? slave1 : 8'($urandom);
      end
    end

    if (rst) begin
      exp_q.delete();
      rises_since_rst = 0;
      drain_mode = 1;
      last_grant = 1;
      in_txn = 0;
      din_bad = 0;
      newd_w = 0;
      ready_prev = 0;
    end else begin
      if (link_newd) newd_w++;
      else if (newd_w != 0) begin
        check("newd_width", 32'(newd_w), 32'd4);
        newd_w = 0;
      end

      if (in_txn && busy && link_din !== gnt_byte) din_bad = 1;

      if (prev_busy && !busy) begin
        if (drain_mode) check("drain_edges", 32'(rises_since_rst), 32'(END_EDGE + GAP_EDGES));
        else begin
          check("gap_edges", 32'(rises_since_rsp), 32'(GAP_EDGES));
          check("din_stable", 32'(din_bad), 32'd0);
          check("din_value", 32'(link_din), 32'(gnt_byte));
        end
        drain_mode = 0;
        in_txn = 0;
        din_bad = 0;
      end

      if (req0_ready || req1_ready) begin
        int exp_id, id;
        id = req1_ready ? 1 : 0;
        check("ready_excl", 32'(req0_ready && req1_ready), 32'd0);
        check("ready_valid", 32'(req1_ready ? req1_valid : req0_valid), 32'd1);
        check("ready_idle", 32'(busy), 32'd0);
`ifdef SPI_DC_PRIO_EN
        exp_id = req0_valid ? 0 : 1;
`else
        exp_id = (req0_valid && req1_valid) ? 1 - last_grant : (req1_valid ? 1 : 0);
`endif
        check("grant_id", 32'(id), 32'(exp_id));
        gnt_byte = id ? req1_data : req0_data;
        exp_q.push_back({id[0], gnt_byte});
        grant_log.push_back(id);
        last_grant = id;
        hs_cnt++;
        in_txn = 1;
        ready_prev = 1;
      end else if (ready_prev) begin
        check("ready_pulse_busy", 32'(busy), 32'd1);
        ready_prev = 0;
      end

      if (rsp_valid) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e[8]));
          check("rsp_data", 32'(rsp_data), 32'(e[7:0]));
          check("rsp_edge", 32'(m_since), 32'(END_EDGE));
        end
        rsp_log.push_back(rsp_data);
        rsp_cnt++;
        rises_since_rsp = 0;
      end
    end
    prev_busy = busy;
  end

  // driver tasks
  task automatic send(input int mask, input logic [7:0] d0, input logic [7:0] d1);
    int i;
    @(posedge clk); #1;
    req0_valid = mask[0];
    req0_data  = d0;
    req1_valid = mask[1];
    req1_data  = d1;
    for (i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) break;
    end
    if (i == BUDGET) check("hs_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == BUDGET) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rb, i;
    logic [7:0] d;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_newd", 32'(link_newd), 32'd0);
    check("rst_din", 32'(link_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    @(negedge link_sclk);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();

    // single request from requester 0
    rb = rsp_log.size();
    send(1, 8'hA5, 8'h00);
    wait_idle();
    check("s_single_cnt", 32'(rsp_log.size() - rb), 32'd1);
    check("s_single_data", 32'(rsp_log[rb]), 32'hA5);

    // back-to-back requester 1
    rb = rsp_log.size();
    send(2, 8'h00, 8'h00);
    send(2, 8'h00, 8'hFF);
    wait_idle();
    check("s_b2b_cnt", 32'(rsp_log.size() - rb), 32'd2);
    check("s_b2b_first", 32'(rsp_log[rb]), 32'h00);
    check("s_b2b_second", 32'(rsp_log[rb + 1]), 32'hFF);

    // both requesters held valid
    base = grant_log.size();
    rb   = rsp_log.size();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    for (i = 0; i < 4 * BUDGET; i++) begin
      @(posedge clk);
      if (hs_cnt >= base + 4) break;
    end
    if (i == 4 * BUDGET) check("s_both_timeout", 32'd1, 32'd0);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("s_both_cnt", 32'(rsp_log.size() - rb), 32'd4);
    for (int k = 0; k < 4; k++) begin
`ifdef SPI_DC_PRIO_EN
      check("s_both_grant", 32'(grant_log[base + k]), 32'd0);
      check("s_both_data", 32'(rsp_log[rb + k]), 32'h11);
`else
      check("s_both_grant", 32'(grant_log[base + k]), 32'(k % 2));
      check("s_both_data", 32'(rsp_log[rb + k]), (k % 2) ? 32'h22 : 32'h11);
`endif
    end

    // requester 0 raises valid only while the arbiter is busy, then withdraws
    base = hs_cnt;
    rb   = rsp_log.size();
    send(2, 8'h00, 8'h3C);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h5A;
    repeat (30) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_idle();
    check("s_withdraw_hs", 32'(hs_cnt - base), 32'd1);
    check("s_withdraw_rsp", 32'(rsp_log.size() - rb), 32'd1);
    check("s_withdraw_data", 32'(rsp_log[rb]), 32'h3C);

    // reset in the middle of a transfer
    rb = rsp_log.size();
    send(1, 8'h96, 8'h00);
    for (i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      if (m_active && m_cnt == 10) break;
    end
    if (i == BUDGET) check("s_abort_timeout", 32'd1, 32'd0);
    @(negedge link_sclk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(2, 8'h00, 8'hC3);
    check("s_abort_drained", 32'(rises_since_rst >= END_EDGE + GAP_EDGES), 32'd1);
    wait_idle();
    check("s_abort_rsp", 32'(rsp_log.size() - rb), 32'd1);
    check("s_abort_data", 32'(rsp_log[rb]), 32'hC3);

    // randomized traffic
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) wait_idle();
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send($urandom_range(1, 3), d, ~d ^ 8'($urandom));
    end
    wait_idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("rsp_total", 32'(rsp_cnt), 32'(hs_cnt - 1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_dc_arbiter.md
SPI_DC_ARBITER -- requirements
Module: spi_dc_arbiter

Interface
REQ-001 Parameter CAP_EDGE, default 27: link_sclk rising-edge index after which link_dout is sampled.
REQ-002 Parameter END_EDGE, default 28: link_sclk rising-edge index that ends a transaction.
REQ-003 Parameter GAP_EDGES, default 2: idle link_sclk rising edges enforced between transactions.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req0_valid / req1_valid  in  1  requester N has a byte to send.
REQ-007 req0_data / req1_data  in  8  requester N transmit byte.
REQ-008 req0_ready / req1_ready  out  1  one-cycle accept pulse; transfer occurs when valid and ready are both high.
REQ-009 rsp_valid  out  1  one-cycle pulse; response byte valid.
REQ-010 rsp_id  out  1  requester index owning the response.
REQ-011 rsp_data  out  8  byte returned through the daisy chain.
REQ-012 busy  out  1  high from grant until end of GAP.
REQ-013 link_sclk  in  1  serial clock from the chain master (clk/8).
REQ-014 link_newd  out  1  start strobe to the chain master.
REQ-015 link_din  out  8  byte to the chain master.
REQ-016 link_dout  in  8  chain master output; valid only within one sclk period after rising edge CAP_EDGE.

Function
REQ-017 link_sclk SHALL be registered twice; rise/fall SHALL be detected from the registered copies only.
REQ-018 FSM states SHALL be: DRAIN, IDLE, ALIGN, START, RUN, CAPTURE, DONE, GAP.
REQ-019 IDLE: if any valid, grant per REQ-027, pulse that ready for one cycle, load link_din with the granted data, latch owner id, go ALIGN.
REQ-020 ALIGN: on detected link_sclk fall, assert link_newd and go START.
REQ-021 START: on the next detected rise, deassert link_newd, set edge counter to 0, go RUN.
REQ-022 RUN: count each detected rise; when count equals CAP_EDGE, go CAPTURE.
REQ-023 CAPTURE: wait 2 clk, latch link_dout into rsp_data, go DONE.
REQ-024 DONE: on the rise making count equal END_EDGE, pulse rsp_valid for exactly one cycle with rsp_id = owner, go GAP.
REQ-025 GAP: after GAP_EDGES further rises, go IDLE; busy drops in the same cycle.
REQ-026 link_din SHALL remain stable from grant until GAP exits.
REQ-027 Arbitration: round-robin; the last-granted requester has lowest priority on the next grant; with only one valid requester, it is granted.
REQ-028 A request deasserted before ready SHALL NOT be granted; no ready pulse is issued outside IDLE.
REQ-029 rsp_valid has no backpressure; a response is never dropped or duplicated.
REQ-030 Edge counter SHALL be 5 bits, saturating at 31.

Reset
REQ-031 On rst: req*_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, link_newd=0, link_din=0, busy=1, round-robin pointer favours requester 0, state=DRAIN.
REQ-032 DRAIN: the link has no reset, so wait END_EDGE+GAP_EDGES detected rises with link_newd low before entering IDLE; busy=1 throughout.
REQ-033 rst asserted mid-transaction SHALL abort it: link_newd drops the next cycle, no rsp_valid for the aborted transfer, DRAIN entered.

Configuration
REQ-034 Macro SPI_DC_PRIO_EN: when defined, requester 0 has fixed priority over requester 1; when undefined, round-robin per REQ-027.

Verification
REQ-035 Bench SHALL model the chain with the two-slave loop and check rsp_data==req byte for each direct scenario below.
REQ-036 Single req0 0xA5 after drain -> req0_ready one pulse, link_newd high for exactly 4 clk, rsp_valid once, rsp_id=0, rsp_data=0xA5.
REQ-037 req0 and req1 both valid continuously (0x11, 0x22) -> grants alternate 0,1,0,1; rsp bytes 0x11,0x22 in order; with SPI_DC_PRIO_EN only req0 granted.
REQ-038 Back-to-back req1 0x00 then 0xFF -> two responses 0x00 then 0xFF; link_din stable across each transaction; no newd during GAP.
REQ-039 rst pulsed at rise 10 of a transfer -> no rsp_valid for it; next request accepted only after END_EDGE+GAP_EDGES rises.
REQ-040 req0_valid raised then dropped while busy -> no grant, no response, ready never pulses.
